// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage: field/immediate decode, operand read with write-back bypass,
// and a registered valid/ready output slot with load-use bubble insertion and flush.
module decode_stage #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned RF_DEPTH = 32,
    parameter int unsigned AW       = $clog2(RF_DEPTH)
) (
    input  logic            clk_100MHz,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction_in,
    input  logic [XLEN-1:0] pc_in,
    output logic [AW-1:0]   rf_raddr1,
    output logic [AW-1:0]   rf_raddr2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [2:0]      out_fmt,
    output logic            out_is_load,
    output logic            out_illegal,
    output logic [31:0]     bubble_count
);

    localparam logic [2:0] FmtR = 3'd0;
    localparam logic [2:0] FmtI = 3'd1;
    localparam logic [2:0] FmtS = 3'd2;
    localparam logic [2:0] FmtB = 3'd3;
    localparam logic [2:0] FmtU = 3'd4;
    localparam logic [2:0] FmtJ = 3'd5;

    localparam logic [6:0] OpLoad    = 7'b0000011;
    localparam logic [6:0] OpMiscMem = 7'b0001111;
    localparam logic [6:0] OpOpImm   = 7'b0010011;
    localparam logic [6:0] OpAuipc   = 7'b0010111;
    localparam logic [6:0] OpStore   = 7'b0100011;
    localparam logic [6:0] OpOp      = 7'b0110011;
    localparam logic [6:0] OpLui     = 7'b0110111;
    localparam logic [6:0] OpBranch  = 7'b1100011;
    localparam logic [6:0] OpJalr    = 7'b1100111;
    localparam logic [6:0] OpJal     = 7'b1101111;
    localparam logic [6:0] OpSystem  = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [2:0]      fmt;
        logic            is_load;
        logic            illegal;
    } slot_t;

    slot_t       slot_q, slot_d, dec;
    logic        valid_q, valid_d;
    logic [31:0] bubble_q, bubble_d;

    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2;
    logic [2:0]  fmt;
    logic        illegal, is_load;
    logic [31:0] imm32;
    logic        uses_rs1, uses_rs2;
    logic        hazard, accept;

    assign opcode    = instruction_in[6:0];
    assign rs1       = instruction_in[19:15];
    assign rs2       = instruction_in[24:20];
    assign rf_raddr1 = AW'(rs1);
    assign rf_raddr2 = AW'(rs2);

    always_comb begin
        fmt     = FmtI;
        illegal = 1'b0;
        is_load = 1'b0;
        case (opcode)
            OpOp:                                fmt = FmtR;
            OpOpImm, OpJalr, OpSystem, OpMiscMem: fmt = FmtI;
            OpLoad: begin
                fmt     = FmtI;
                is_load = 1'b1;
            end
            OpStore:                             fmt = FmtS;
            OpBranch:                            fmt = FmtB;
            OpLui, OpAuipc:                      fmt = FmtU;
            OpJal:                               fmt = FmtJ;
            default:                             illegal = 1'b1;
        endcase
    end

    always_comb begin
        imm32 = '0;
        if (!illegal) begin
            case (fmt)
                FmtI: imm32 = {{20{instruction_in[31]}}, instruction_in[31:20]};
                FmtS: imm32 = {{20{instruction_in[31]}}, instruction_in[31:25],
                               instruction_in[11:7]};
                FmtB: imm32 = {{19{instruction_in[31]}}, instruction_in[31], instruction_in[7],
                               instruction_in[30:25], instruction_in[11:8], 1'b0};
                FmtU: imm32 = {instruction_in[31:12], 12'b0};
                FmtJ: imm32 = {{11{instruction_in[31]}}, instruction_in[31],
                               instruction_in[19:12], instruction_in[20],
                               instruction_in[30:21], 1'b0};
                default: imm32 = '0;
            endcase
        end
    end

    assign uses_rs1 = (fmt == FmtR) || (fmt == FmtI) || (fmt == FmtS) || (fmt == FmtB);
    assign uses_rs2 = (fmt == FmtR) || (fmt == FmtS) || (fmt == FmtB);

    // x0 reads as zero and is never bypassed; a same-cycle write-back wins over the RF.
    function automatic logic [XLEN-1:0] read_operand(input logic [4:0]      src,
                                                     input logic [XLEN-1:0] rf_data,
                                                     input logic            wen,
                                                     input logic [AW-1:0]   waddr,
                                                     input logic [XLEN-1:0] wdata);
        if (src == 5'd0) begin
            return '0;
        end else if (wen && (waddr == AW'(src))) begin
            return wdata;
        end
        return rf_data;
    endfunction

    always_comb begin
        dec          = '0;
        dec.pc       = pc_in;
        dec.rs1_data = read_operand(rs1, rf_rdata1, wb_en, wb_addr, wb_data);
        dec.rs2_data = read_operand(rs2, rf_rdata2, wb_en, wb_addr, wb_data);
        dec.rs1      = rs1;
        dec.rs2      = rs2;
        dec.rd       = (illegal || fmt == FmtS || fmt == FmtB) ? 5'd0 : instruction_in[11:7];
        dec.imm      = XLEN'($signed(imm32));
        dec.opcode   = opcode;
        dec.funct3   = instruction_in[14:12];
        dec.funct7   = instruction_in[31:25];
        dec.fmt      = fmt;
        dec.is_load  = is_load;
        dec.illegal  = illegal;
    end

    assign hazard = in_valid && valid_q && slot_q.is_load && (slot_q.rd != 5'd0) &&
                    ((uses_rs1 && rs1 == slot_q.rd) || (uses_rs2 && rs2 == slot_q.rd));
    assign in_ready = !flush && !hazard && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        slot_d   = slot_q;
        valid_d  = valid_q;
        bubble_d = bubble_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            slot_d  = dec;
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
            // The load drains while its dependent waits: that empty cycle is the bubble.
            if (hazard && (bubble_q != 32'hFFFF_FFFF)) begin
                bubble_d = bubble_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            slot_q   <= '0;
            valid_q  <= 1'b0;
            bubble_q <= '0;
        end else begin
            slot_q   <= slot_d;
            valid_q  <= valid_d;
            bubble_q <= bubble_d;
        end
    end

    assign out_valid    = valid_q;
    assign out_pc       = slot_q.pc;
    assign out_rs1_data = slot_q.rs1_data;
    assign out_rs2_data = slot_q.rs2_data;
    assign out_rs1      = slot_q.rs1;
    assign out_rs2      = slot_q.rs2;
    assign out_rd       = slot_q.rd;
    assign out_imm      = slot_q.imm;
    assign out_opcode   = slot_q.opcode;
    assign out_funct3   = slot_q.funct3;
    assign out_funct7   = slot_q.funct7;
    assign out_fmt      = slot_q.fmt;
    assign out_is_load  = slot_q.is_load;
    assign out_illegal  = slot_q.illegal;
    assign bubble_count = bubble_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: immediates, load-use bubbles, backpressure, bypass,
// flush, illegal opcodes and reset during a stall.
module tb_decode_stage;

    logic        clk_100MHz = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instruction_in = '0;
    logic [31:0] pc_in = '0;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm, bubble_count;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [6:0]  out_opcode, out_funct7;
    logic [2:0]  out_funct3, out_fmt;
    logic        out_is_load, out_illegal;

    logic [31:0] rf [32];
    int checks = 0;
    int failures = 0;

    assign rf_rdata1 = rf[rf_raddr1];
    assign rf_rdata2 = rf[rf_raddr2];

    always #5 clk_100MHz = ~clk_100MHz;

    decode_stage #(.XLEN(32), .RF_DEPTH(32)) dut (
        .clk_100MHz(clk_100MHz), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instruction_in(instruction_in), .pc_in(pc_in),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_fmt(out_fmt), .out_is_load(out_is_load), .out_illegal(out_illegal),
        .bubble_count(bubble_count)
    );

    task automatic step();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", out_valid); end
        checks++; if (bubble_count !== 32'd0) begin failures++; $display("FAIL rst_bubble got=%0d exp=0", bubble_count); end
        checks++; if (out_imm !== 32'd0 || out_pc !== 32'd0 || out_rd !== 5'd0) begin failures++; $display("FAIL rst_payload imm=%h pc=%h rd=%0d exp=0", out_imm, out_pc, out_rd); end
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_immediates();
        out_ready = 1'b1;
        in_valid = 1'b1; instruction_in = 32'hFFF08293; pc_in = 32'h100;
        step();
        instruction_in = 32'h0021A423; pc_in = 32'h104;
        checks++; if (out_valid !== 1'b1 || out_imm !== 32'hFFFFFFFF || out_rd !== 5'd5 || out_fmt !== 3'd1) begin failures++; $display("FAIL imm_addi v=%0b imm=%h rd=%0d fmt=%0d exp 1/ffffffff/5/1", out_valid, out_imm, out_rd, out_fmt); end
        checks++; if (out_pc !== 32'h100 || out_rs1_data !== 32'h10000001) begin failures++; $display("FAIL addi_pc_rs1 pc=%h rs1d=%h exp 100/10000001", out_pc, out_rs1_data); end
        step();
        instruction_in = 32'hFFDFF0EF; pc_in = 32'h108;
        checks++; if (out_valid !== 1'b1 || out_imm !== 32'h8 || out_rd !== 5'd0 || out_fmt !== 3'd2) begin failures++; $display("FAIL imm_sw v=%0b imm=%h rd=%0d fmt=%0d exp 1/8/0/2", out_valid, out_imm, out_rd, out_fmt); end
        checks++; if (out_rs1 !== 5'd3 || out_rs2_data !== 32'h10000002) begin failures++; $display("FAIL sw_srcs rs1=%0d rs2d=%h exp 3/10000002", out_rs1, out_rs2_data); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_imm !== 32'hFFFFFFFC || out_rd !== 5'd1 || out_fmt !== 3'd5 || out_pc !== 32'h108) begin failures++; $display("FAIL imm_jal v=%0b imm=%h rd=%0d fmt=%0d pc=%h exp 1/fffffffc/1/5/108", out_valid, out_imm, out_rd, out_fmt, out_pc); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL imm_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_load_use();
        in_valid = 1'b1; instruction_in = 32'h0000A283; pc_in = 32'h200;
        step();
        instruction_in = 32'h00228333; pc_in = 32'h204;
        #1;
        checks++; if (in_ready !== 1'b0 || out_is_load !== 1'b1) begin failures++; $display("FAIL lu_stall in_ready=%0b is_load=%0b exp 0/1", in_ready, out_is_load); end
        step();
        checks++; if (out_valid !== 1'b0 || bubble_count !== 32'd1) begin failures++; $display("FAIL lu_bubble v=%0b cnt=%0d exp 0/1", out_valid, bubble_count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL lu_release got=%0b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_rd !== 5'd6 || out_rs1 !== 5'd5 || out_pc !== 32'h204) begin failures++; $display("FAIL lu_add v=%0b rd=%0d rs1=%0d pc=%h exp 1/6/5/204", out_valid, out_rd, out_rs1, out_pc); end
        step();
        // Load to x0 never creates a dependency.
        in_valid = 1'b1; instruction_in = 32'h0000A003; pc_in = 32'h210;
        step();
        instruction_in = 32'h00228333; pc_in = 32'h214;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL lu_x0_ready got=%0b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h214 || bubble_count !== 32'd1) begin failures++; $display("FAIL lu_x0_nobubble v=%0b pc=%h cnt=%0d exp 1/214/1", out_valid, out_pc, bubble_count); end
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; instruction_in = 32'hFFF08293; pc_in = 32'h300;
        step();
        instruction_in = 32'h0021A423; pc_in = 32'h304;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h300 || out_imm !== 32'hFFFFFFFF || out_rd !== 5'd5) begin failures++; $display("FAIL bp_hold%0d rdy=%0b v=%0b pc=%h imm=%h rd=%0d", i, in_ready, out_valid, out_pc, out_imm, out_rd); end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%0b exp=1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h304 || out_imm !== 32'h8) begin failures++; $display("FAIL bp_next v=%0b pc=%h imm=%h exp 1/304/8", out_valid, out_pc, out_imm); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_nodup got=%0b exp=0", out_valid); end
    endtask

    task automatic test_bypass();
        rf[1] = 32'h0;
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'hDEADBEEF;
        in_valid = 1'b1; instruction_in = 32'hFFF08293; pc_in = 32'h400;
        #1;
        checks++; if (rf_raddr1 !== 5'd1 || rf_raddr2 !== 5'd31) begin failures++; $display("FAIL raddr r1=%0d r2=%0d exp 1/31", rf_raddr1, rf_raddr2); end
        step();
        wb_addr = 5'd0; wb_data = 32'h12345678;
        instruction_in = 32'h00100293; pc_in = 32'h404;
        checks++; if (out_rs1_data !== 32'hDEADBEEF) begin failures++; $display("FAIL byp_hit got=%h exp=deadbeef", out_rs1_data); end
        step();
        in_valid = 1'b0; wb_en = 1'b0;
        checks++; if (out_rs1_data !== 32'h0 || out_imm !== 32'h1) begin failures++; $display("FAIL byp_x0 rs1d=%h imm=%h exp 0/1", out_rs1_data, out_imm); end
        rf[1] = 32'h10000001;
        step();
    endtask

    task automatic test_flush_illegal();
        in_valid = 1'b1; instruction_in = 32'hFFF08293; pc_in = 32'h500;
        step();
        flush = 1'b1; instruction_in = 32'h0021A423; pc_in = 32'h504;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fl_ready got=%0b exp=0", in_ready); end
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fl_clear got=%0b exp=0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fl_notaken got=%0b exp=0", out_valid); end
        in_valid = 1'b1; instruction_in = 32'hFFFFFFFF; pc_in = 32'h508;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_imm !== 32'h0 || out_rd !== 5'd0 || out_fmt !== 3'd1) begin failures++; $display("FAIL illegal v=%0b ill=%0b imm=%h rd=%0d fmt=%0d exp 1/1/0/0/1", out_valid, out_illegal, out_imm, out_rd, out_fmt); end
        step();
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b0;
        in_valid = 1'b1; instruction_in = 32'h0000A283; pc_in = 32'h600;
        step();
        instruction_in = 32'h00228333; pc_in = 32'h604;
        step();
        checks++; if (out_valid !== 1'b1 || out_is_load !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL rs_stall v=%0b ld=%0b rdy=%0b exp 1/1/0", out_valid, out_is_load, in_ready); end
        reset = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || bubble_count !== 32'd0 || out_pc !== 32'd0 || out_rd !== 5'd0 || out_is_load !== 1'b0) begin failures++; $display("FAIL rs_clear v=%0b cnt=%0d pc=%h rd=%0d ld=%0b exp all 0", out_valid, bubble_count, out_pc, out_rd, out_is_load); end
        reset = 1'b0; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rs_ready got=%0b exp=1", in_ready); end
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h10000000 | i;
        test_reset();
        test_immediates();
        test_load_use();
        test_backpressure();
        test_bypass();
        test_flush_illegal();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised RV32I/RV64I instruction-decode pipeline stage between fetch and execute. Each accepted instruction is decoded, all five immediate formats are generated and sign-extended to XLEN, and register-file operands are read with a write-back bypass. Results are registered into a valid/ready output slot. The stage detects load-use hazards against the instruction in its output slot, inserts a single bubble, supports a pipeline flush, and counts inserted bubbles.

## Interface

**Parameters**
- XLEN, 32: datapath width (32 or 64); immediates and operands are sign-extended to this width.
- RF_DEPTH, 32: register-file entries.
- AW, $clog2(RF_DEPTH): register-address width.

**Ports**
- clk_100MHz  in  1  clock.
- reset  in  1  synchronous, active-high.
- flush  in  1  discards the output slot and blocks input this cycle.
- in_valid  in  1  instruction_in/pc_in valid.
- in_ready  out  1  stage accepts input this cycle.
- instruction_in  in  32  fetched instruction.
- pc_in  in  XLEN  instruction address.
- rf_raddr1, rf_raddr2  out  AW  combinational; equal to instruction_in[19:15] and [24:20].
- rf_rdata1, rf_rdata2  in  XLEN  combinational RF read data.
- wb_en  in  1  write-back strobe.
- wb_addr  in  AW  write-back address.
- wb_data  in  XLEN  write-back data.
- out_valid  out  1  output slot valid.
- out_ready  in  1  execute consumes the slot.
- out_pc  out  XLEN
- out_rs1_data, out_rs2_data  out  XLEN
- out_rs1, out_rs2, out_rd  out  5
- out_imm  out  XLEN
- out_opcode  out  7
- out_funct3  out  3
- out_funct7  out  7
- out_fmt  out  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J.
- out_is_load  out  1
- out_illegal  out  1
- bubble_count  out  32  saturating count of inserted bubbles.

## Operation

**Format by opcode**
- OP → R.
- OP_IMM, LOAD, JALR, SYSTEM, MISC_MEM → I.
- STORE → S.
- BRANCH → B.
- LUI, AUIPC → U.
- JAL → J.
- Any other opcode → out_illegal=1, out_imm=0, out_rd=0, fmt=I.

**Immediates** (all sign-extended from instr[31] to XLEN)
- I: instr[31:20].
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
- U: {instr[31:12], 12'b0}.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
- R format: imm=0.

**Destination and source use**
- out_rd is forced to 0 for S, B and illegal instructions.
- rs1 is used by R, I, S and B formats; rs2 is used by R, S and B formats.

**Operand read**
- Source register index 0 → data 0.
- Else if wb_en && wb_addr==src → wb_data.
- Else rf_rdata.

**Load-use hazard**
- hazard = in_valid && out_valid && out_is_load && out_rd!=0 && ((uses_rs1 && rs1==out_rd) || (uses_rs2 && rs2==out_rd)).

**Handshake**
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- Accept (in_valid && in_ready): the slot loads all decoded fields and out_valid←1.
- If out_ready && !accept: out_valid←0.
- If hazard && out_ready: the slot empties (bubble) and bubble_count increments, saturating at 0xFFFFFFFF.
- Otherwise the slot holds unchanged.

**Flush and reset**
- flush: out_valid←0; no accept; bubble_count unchanged.
- reset has priority over flush.

## Timing

- Latency: one cycle from accept to out_valid.
- Throughput: one instruction per cycle with no hazard and out_ready=1.
- Reset values: all out_* = 0, out_valid=0, bubble_count=0.
- in_ready and rf_raddr* are combinational from current inputs and slot state.
- Payload fields hold stable while out_valid && !out_ready.
- Load-use costs exactly one bubble cycle. On the next cycle the load has left the slot, so the dependent instruction is accepted.
- Reset asserted mid-stall: the slot and counter clear on the next edge, and any pending instruction is dropped.
- wb write and read of the same register in the same cycle returns the new data.
- wb_addr=0 is never bypassed.

## Test plan

- **Immediates:** 0xFFF08293 (addi x5,x1,-1), then 0x0021A423 (sw x2,8(x3)), then 0xFFDFF0EF (jal x1,-4), with out_ready=1.
  - -> imm 0xFFFFFFFF/rd 5/fmt 1, then imm 0x8/rd 0/fmt 2, then imm 0xFFFFFFFC/rd 1/fmt 5.
  - Each arrives one cycle after accept, back-to-back.
- **Load-use:** 0x0000A283 (lw x5,0(x1)) then 0x00228333 (add x6,x5,x2), out_ready=1.
  - -> in_ready=0 for one cycle, one out_valid=0 cycle, then add valid; bubble_count=1.
  - Repeat with rd=x0 -> no bubble.
- **Backpressure:** out_ready=0 for 3 cycles with in_valid=1.
  - -> in_ready=0 and all out_* constant.
  - out_ready=1 -> next instruction appears the following cycle, none lost or duplicated.
- **Bypass:** accept rs1=x1 while wb_en=1, wb_addr=1, wb_data=0xDEADBEEF, rf_rdata1=0x0 -> out_rs1_data=0xDEADBEEF.
  - wb_addr=0 with rs1=x0 -> out_rs1_data=0.
- **Flush and illegal:** flush with slot valid -> out_valid=0 next cycle, input in the flush cycle not consumed.
  - Opcode 0x7F -> out_illegal=1, imm=0, rd=0.
- **Reset mid-operation:** reset asserted during a hazard stall -> next cycle all outputs 0, bubble_count=0, in_ready=1 once reset deasserts.
